// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame loader: parity modes, receiver
// state encoding and the small constant helpers used to size counters.
package uart_frame_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } rx_state_e;

   // Clocks per oversample tick; never less than one so the divider stays legal.
   function automatic int calc_div(input int clk_rate, input int baud_rate, input int sample_rate);
      int d;
      d = clk_rate / (baud_rate * sample_rate);
      return (d < 1) ? 1 : d;
   endfunction

   // Ceiling log2 with a floor of one bit so every counter has a real width.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/uart_oversample_tick.sv
// Free-running divider that emits a one-clock tick every DIV clocks.
module uart_oversample_tick
   import uart_frame_pkg::*;
#(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = (cnt_q == LAST);

   // Count up and wrap to zero on the tick cycle.
   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   // Divider register, cleared by the active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_frame_loader.sv
// Oversampling UART receiver with majority voting that writes accepted
// bytes into image memory in raster order and flags frame completion.
module uart_frame_loader
   import uart_frame_pkg::*;
#(
   parameter int CLK_RATE    = 9600000,
   parameter int BAUD_RATE   = 9600,
   parameter int SAMPLE_RATE = 16,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int IMG_W       = 50,
   parameter int IMG_H       = 50,
   parameter int ADDR_W      = 14
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       RsRx,
   input  logic                       clear,
   output logic                       mem_we,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_BITS-1:0]       mem_data,
   output logic [clog2(IMG_H)-1:0]    row,
   output logic [clog2(IMG_W)-1:0]    col,
   output logic                       frame_done,
   output logic                       err_frame,
   output logic                       err_parity,
   output logic [7:0]                 err_count
);

   localparam int DIV = calc_div(CLK_RATE, BAUD_RATE, SAMPLE_RATE);
   localparam int TW  = clog2(SAMPLE_RATE);
   localparam int RW  = clog2(IMG_H);
   localparam int CLW = clog2(IMG_W);

   localparam logic [TW-1:0]     T_SAMP0   = TW'(SAMPLE_RATE / 2 - 1);
   localparam logic [TW-1:0]     T_SAMP1   = TW'(SAMPLE_RATE / 2);
   localparam logic [TW-1:0]     T_VOTE    = TW'(SAMPLE_RATE / 2 + 1);
   localparam logic [TW-1:0]     T_LAST    = TW'(SAMPLE_RATE - 1);
   localparam logic [3:0]        BITS_LAST = 4'(DATA_BITS - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [CLW-1:0]    LAST_COL  = CLW'(IMG_W - 1);

   logic tick;
   logic rx_meta_q, rx_sync_q;

   rx_state_e            state_q, state_d;
   logic [TW-1:0]        tcnt_q, tcnt_d;
   logic [3:0]           bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [1:0]           samp_q, samp_d;
   logic                 par_ok_q, par_ok_d;

   logic voted, exp_par, on_vote, bit_end;
   logic accept, bad_frame, bad_parity;

   logic                 mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic [DATA_BITS-1:0] mem_data_q, mem_data_d;
   logic [ADDR_W-1:0]    index_q, index_d;
   logic [RW-1:0]        row_q, row_d;
   logic [CLW-1:0]       col_q, col_d;
   logic                 frame_done_q, frame_done_d;
   logic                 err_frame_q, err_frame_d;
   logic                 err_parity_q, err_parity_d;
   logic [7:0]           err_count_q, err_count_d;

   uart_oversample_tick #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign voted   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);
   assign exp_par = (PARITY == PAR_EVEN) ? ^shift_q : ~^shift_q;
   assign on_vote = tick && (tcnt_q == T_VOTE);
   assign bit_end = tick && (tcnt_q == T_LAST);

   // Two-flop synchroniser on the asynchronous line, idling high out of reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= RsRx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // Receiver next state: bit timing, sample capture, voting and frame outcome.
   always_comb begin
      state_d    = state_q;
      tcnt_d     = tcnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      samp_d     = samp_q;
      par_ok_d   = par_ok_q;
      accept     = 1'b0;
      bad_frame  = 1'b0;
      bad_parity = 1'b0;

      if (tick && (tcnt_q == T_SAMP0)) samp_d[0] = rx_sync_q;
      if (tick && (tcnt_q == T_SAMP1)) samp_d[1] = rx_sync_q;
      if (tick) tcnt_d = bit_end ? '0 : tcnt_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (tick && !rx_sync_q) begin
               state_d   = ST_START;
               tcnt_d    = TW'(1);
               bit_idx_d = '0;
               par_ok_d  = 1'b1;
            end
         end
         ST_START: begin
            if (on_vote && voted) state_d = ST_IDLE;
            else if (bit_end)     state_d = ST_DATA;
         end
         ST_DATA: begin
            if (on_vote) shift_d = {voted, shift_q[DATA_BITS-1:1]};
            if (bit_end) begin
               if (bit_idx_q == BITS_LAST) state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               else                        bit_idx_d = bit_idx_q + 1'b1;
            end
         end
         ST_PARITY: begin
            if (on_vote) par_ok_d = (voted == exp_par);
            if (bit_end) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (on_vote) begin
               if (!voted) begin
                  bad_frame = 1'b1;
                  state_d   = ST_BREAK;
               end else if (!par_ok_q) begin
                  bad_parity = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  accept  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_BREAK: begin
            if (tick && rx_sync_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Collector next state: raster addressing, completion, clear and error counting.
   always_comb begin
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      index_d      = index_q;
      row_d        = row_q;
      col_d        = col_q;
      frame_done_d = frame_done_q;
      err_frame_d  = bad_frame;
      err_parity_d = bad_parity;
      err_count_d  = err_count_q;

      if ((bad_frame || bad_parity) && (err_count_q != 8'hFF)) err_count_d = err_count_q + 1'b1;

      if (clear) begin
         index_d      = '0;
         row_d        = '0;
         col_d        = '0;
         frame_done_d = 1'b0;
         err_count_d  = '0;
      end else if (accept && !frame_done_q) begin
         mem_we_d   = 1'b1;
         mem_addr_d = index_q;
         mem_data_d = shift_q;
         if (index_q == LAST_ADDR) begin
            frame_done_d = 1'b1;
            index_d      = '0;
            row_d        = '0;
            col_d        = '0;
         end else begin
            index_d = index_q + 1'b1;
            if (col_q == LAST_COL) begin
               col_d = '0;
               row_d = row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
      end
   end

   // State and output registers, all cleared by the active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         tcnt_q       <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         samp_q       <= '0;
         par_ok_q     <= 1'b1;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         index_q      <= '0;
         row_q        <= '0;
         col_q        <= '0;
         frame_done_q <= 1'b0;
         err_frame_q  <= 1'b0;
         err_parity_q <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         tcnt_q       <= tcnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         samp_q       <= samp_d;
         par_ok_q     <= par_ok_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         index_q      <= index_d;
         row_q        <= row_d;
         col_q        <= col_d;
         frame_done_q <= frame_done_d;
         err_frame_q  <= err_frame_d;
         err_parity_q <= err_parity_d;
         err_count_q  <= err_count_d;
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_data   = mem_data_q;
   assign row        = row_q;
   assign col        = col_q;
   assign frame_done = frame_done_q;
   assign err_frame  = err_frame_q;
   assign err_parity = err_parity_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: one instance without parity and one with even
// parity, a write scoreboard per instance and error pulse counters.
module tb_uart_frame_loader;

   localparam int BIT_CLKS = 160;

   typedef struct packed {
      logic [2:0] addr;
      logic [7:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rxA = 1'b1;
   logic rxB = 1'b1;
   logic clearA = 1'b0;
   logic clearB = 1'b0;

   logic       weA, doneA, errFA, errPA;
   logic [2:0] addrA;
   logic [7:0] dataA, errCntA;
   logic [0:0] rowA;
   logic [1:0] colA;

   logic       weB, doneB, errFB, errPB;
   logic [2:0] addrB;
   logic [7:0] dataB, errCntB;
   logic [0:0] rowB;
   logic [1:0] colB;

   int total = 0;
   int bad = 0;
   int nWrA = 0, nWrB = 0, expWrA = 0, expWrB = 0;
   int nErrFA = 0, nErrPA = 0, nErrFB = 0, nErrPB = 0;
   wr_t qA[$];
   wr_t qB[$];
   wr_t eA, eB;
   logic [7:0] d6 = 8'h77;

   uart_frame_loader #(
      .CLK_RATE(1600000), .BAUD_RATE(10000), .SAMPLE_RATE(16), .DATA_BITS(8),
      .PARITY(0), .IMG_W(4), .IMG_H(2), .ADDR_W(3)
   ) dut (
      .clk(clk), .rst(rst), .RsRx(rxA), .clear(clearA),
      .mem_we(weA), .mem_addr(addrA), .mem_data(dataA), .row(rowA), .col(colA),
      .frame_done(doneA), .err_frame(errFA), .err_parity(errPA), .err_count(errCntA)
   );

   uart_frame_loader #(
      .CLK_RATE(1600000), .BAUD_RATE(10000), .SAMPLE_RATE(16), .DATA_BITS(8),
      .PARITY(2), .IMG_W(4), .IMG_H(2), .ADDR_W(3)
   ) dutPar (
      .clk(clk), .rst(rst), .RsRx(rxB), .clear(clearB),
      .mem_we(weB), .mem_addr(addrB), .mem_data(dataB), .row(rowB), .col(colB),
      .frame_done(doneB), .err_frame(errFB), .err_parity(errPB), .err_count(errCntB)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic pushA(input logic [2:0] a, input logic [7:0] d);
      qA.push_back({a, d});
      expWrA++;
   endtask

   task automatic pushB(input logic [2:0] a, input logic [7:0] d);
      qB.push_back({a, d});
      expWrB++;
   endtask

   // Hold one of the two serial lines at a level for n clocks.
   task automatic driveBit(input bit toB, input logic v, input int n);
      if (toB) rxB = v;
      else     rxA = v;
      repeat (n) @(posedge clk);
   endtask

   // Send one frame: start, 8 data bits LSB first, optional parity, stop level
   // held for stopBits bit times, then one idle bit time.
   task automatic applyStimulus(input bit toB, input logic [7:0] d, input bit hasPar,
                                input logic parBit, input logic stopBit, input int stopBits);
      driveBit(toB, 1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) driveBit(toB, d[i], BIT_CLKS);
      if (hasPar) driveBit(toB, parBit, BIT_CLKS);
      driveBit(toB, stopBit, BIT_CLKS * stopBits);
      driveBit(toB, 1'b1, BIT_CLKS);
   endtask

   task automatic pulseClearA();
      @(negedge clk);
      clearA = 1'b1;
      @(negedge clk);
      clearA = 1'b0;
   endtask

   // Scoreboard for the no-parity instance: every write must match the queue head.
   always @(negedge clk) begin
      if (rst) begin
         if (weA) begin
            nWrA++;
            if (qA.size() == 0) begin
               checkOutput("A_spurious_we", {31'd0, weA}, 32'd0);
            end else begin
               eA = qA.pop_front();
               checkOutput("A_addr", {29'd0, addrA}, {29'd0, eA.addr});
               checkOutput("A_data", {24'd0, dataA}, {24'd0, eA.data});
               checkOutput("A_done_with_we", {31'd0, doneA}, {31'd0, (eA.addr == 3'd7)});
            end
         end
         if (errFA) nErrFA++;
         if (errPA) nErrPA++;
      end
   end

   // Scoreboard for the even-parity instance.
   always @(negedge clk) begin
      if (rst) begin
         if (weB) begin
            nWrB++;
            if (qB.size() == 0) begin
               checkOutput("B_spurious_we", {31'd0, weB}, 32'd0);
            end else begin
               eB = qB.pop_front();
               checkOutput("B_addr", {29'd0, addrB}, {29'd0, eB.addr});
               checkOutput("B_data", {24'd0, dataB}, {24'd0, eB.data});
            end
         end
         if (errFB) nErrFB++;
         if (errPB) nErrPB++;
      end
   end

   initial begin
      repeat (5) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_we", {31'd0, weA}, 32'd0);
      checkOutput("rst_addr", {29'd0, addrA}, 32'd0);
      checkOutput("rst_rowcol", {29'd0, rowA, colA}, 32'd0);
      checkOutput("rst_done", {31'd0, doneA}, 32'd0);
      checkOutput("rst_errcnt", {24'd0, errCntA}, 32'd0);
      rst = 1'b1;
      repeat (20) @(posedge clk);

      $display("[TB] single byte 0xA5");
      pushA(3'd0, 8'hA5);
      applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1);
      checkOutput("t1_writes", nWrA, expWrA);
      checkOutput("t1_col", {30'd0, colA}, 32'd1);
      checkOutput("t1_row", {31'd0, rowA}, 32'd0);
      checkOutput("t1_errs", nErrFA + nErrPA, 32'd0);

      $display("[TB] full frame of 8 bytes");
      pulseClearA();
      for (int i = 0; i < 8; i++) begin
         pushA(3'(i), 8'(i));
         applyStimulus(1'b0, 8'(i), 1'b0, 1'b0, 1'b1, 1);
         if (i == 3) begin
            checkOutput("t2_row_after4", {31'd0, rowA}, 32'd1);
            checkOutput("t2_col_after4", {30'd0, colA}, 32'd0);
            checkOutput("t2_done_early", {31'd0, doneA}, 32'd0);
         end
      end
      checkOutput("t2_done", {31'd0, doneA}, 32'd1);
      checkOutput("t2_rowcol_hold", {29'd0, rowA, colA}, 32'd0);
      applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1);
      checkOutput("t2_writes", nWrA, expWrA);
      checkOutput("t2_done_sticky", {31'd0, doneA}, 32'd1);

      $display("[TB] glitches");
      pulseClearA();
      checkOutput("t3_done_cleared", {31'd0, doneA}, 32'd0);
      // A full bit time low followed by high line is a legal start: it decodes as 0xFF.
      pushA(3'd0, 8'hFF);
      driveBit(1'b0, 1'b0, BIT_CLKS);
      driveBit(1'b0, 1'b1, BIT_CLKS * 11);
      driveBit(1'b0, 1'b0, 30);
      driveBit(1'b0, 1'b1, BIT_CLKS * 12);
      checkOutput("t3_writes", nWrA, expWrA);
      pushA(3'd1, 8'h3C);
      applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1);
      checkOutput("t3_valid_after", nWrA, expWrA);

      $display("[TB] framing error and break");
      applyStimulus(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 3);
      checkOutput("t5_errframe", nErrFA, 32'd1);
      checkOutput("t5_errcnt", {24'd0, errCntA}, 32'd1);
      checkOutput("t5_nowrite", nWrA, expWrA);
      pushA(3'd2, 8'h12);
      applyStimulus(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 1);
      checkOutput("t5_next_write", nWrA, expWrA);
      checkOutput("t5_col", {30'd0, colA}, 32'd3);
      checkOutput("t5_errframe_once", nErrFA, 32'd1);

      $display("[TB] even parity");
      applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1);
      checkOutput("t4_errparity", nErrPB, 32'd1);
      checkOutput("t4_errcnt", {24'd0, errCntB}, 32'd1);
      checkOutput("t4_nowrite", nWrB, expWrB);
      pushB(3'd0, 8'h03);
      applyStimulus(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1);
      checkOutput("t4_write", nWrB, expWrB);
      checkOutput("t4_col", {30'd0, colB}, 32'd1);
      checkOutput("t4_errparity_once", nErrPB + nErrFB, 32'd1);

      $display("[TB] clear during acceptance");
      // clear is held across the whole stop bit so it overlaps the acceptance cycle.
      driveBit(1'b0, 1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) driveBit(1'b0, d6[i], BIT_CLKS);
      @(negedge clk);
      clearA = 1'b1;
      driveBit(1'b0, 1'b1, BIT_CLKS);
      @(negedge clk);
      clearA = 1'b0;
      driveBit(1'b0, 1'b1, BIT_CLKS);
      checkOutput("t6_nowrite", nWrA, expWrA);
      checkOutput("t6_rowcol", {29'd0, rowA, colA}, 32'd0);
      checkOutput("t6_done", {31'd0, doneA}, 32'd0);
      checkOutput("t6_errcnt", {24'd0, errCntA}, 32'd0);

      $display("[TB] reset mid byte");
      driveBit(1'b0, 1'b0, BIT_CLKS);
      driveBit(1'b0, 1'b1, BIT_CLKS);
      driveBit(1'b0, 1'b0, BIT_CLKS);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("t6_rst_addr", {29'd0, addrA}, 32'd0);
      checkOutput("t6_rst_data", {24'd0, dataA}, 32'd0);
      checkOutput("t6_rst_we", {31'd0, weA}, 32'd0);
      checkOutput("t6_rst_B_data", {24'd0, dataB}, 32'd0);
      checkOutput("t6_rst_B_col", {30'd0, colB}, 32'd0);
      rxA = 1'b1;
      rst = 1'b1;
      repeat (BIT_CLKS * 12) @(posedge clk);
      checkOutput("t6_rst_nowrite", nWrA, expWrA);

      checkOutput("qA_empty", qA.size(), 32'd0);
      checkOutput("qB_empty", qB.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
